// File: rtl/ysyx_25030093_csr_pkg.sv
// ysyx_25030093_csr_pkg: CSR addresses, operation encodings and mstatus layout
package ysyx_25030093_csr_pkg;
    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;
endpackage

// File: rtl/ysyx_25030093_csr_counter64.sv
// ysyx_25030093_csr_counter64: double-width counter with independently writable halves
module ysyx_25030093_csr_counter64 #(
    parameter int W = 32
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           inc,
    input  logic           lo_we,
    input  logic           hi_we,
    input  logic [W-1:0]   wdata,
    output logic [2*W-1:0] value
);
    logic [W-1:0] lo, hi;
    logic [W:0]   lo_sum;

    assign lo_sum = {1'b0, lo} + (W+1)'(inc);
    assign value  = {hi, lo};

    // a low-half write suppresses the carry; a high-half write discards it
    always_ff @(posedge clock) begin
        if (reset) begin
            lo <= '0;
            hi <= '0;
        end else begin
            lo <= lo_we ? wdata : lo_sum[W-1:0];
            hi <= hi_we ? wdata : lo_we ? hi : hi + W'(lo_sum[W]);
        end
    end
endmodule

// File: rtl/ysyx_25030093_csr_file.sv
// ysyx_25030093_csr_file: machine-mode CSRs with read-modify-write ops,
// illegal-access detection, trap/mret stacking and mcycle/minstret counters
module ysyx_25030093_csr_file
    import ysyx_25030093_csr_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter logic [31:0] VENDOR_ID    = 32'h79737978,
    parameter logic [31:0] ARCH_ID      = 32'd25030093,
    parameter bit          HAS_MINSTRET = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_src,
    input  logic            src_is_zero,
    output logic [XLEN-1:0] csr_rdata,
    output logic            illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_valid,
    input  logic            retire_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            mie_out
);
    logic              mie, mpie;
    logic [XLEN-1:0]   mtvec, mepc, mcause, mscratch, old, wdata;
    logic [2*XLEN-1:0] mcycle, minstret;
    logic              implemented, read_only, write_attempt, active, we;

    always_comb begin
        old = '0;
        implemented = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:            old = XLEN'(MSTATUS_RESET) | (XLEN'(mpie) << MSTATUS_MPIE) | (XLEN'(mie) << MSTATUS_MIE);
            CSR_MTVEC:              old = mtvec;
            CSR_MEPC:               old = mepc;
            CSR_MCAUSE:             old = mcause;
            CSR_MSCRATCH:           old = mscratch;
            CSR_MCYCLE, CSR_CYCLE:  old = mcycle[XLEN-1:0];
            CSR_MCYCLEH, CSR_CYCLEH: old = mcycle[2*XLEN-1:XLEN];
            CSR_MINSTRET:           old = minstret[XLEN-1:0];
            CSR_MINSTRETH:          old = minstret[2*XLEN-1:XLEN];
            CSR_MVENDORID:          old = XLEN'(VENDOR_ID);
            CSR_MARCHID:            old = XLEN'(ARCH_ID);
            default:                implemented = 1'b0;
        endcase
    end

    // RS/RC with a zero source is a pure read, so it is legal even on read-only CSRs
    assign write_attempt = !((csr_op == CSR_RS || csr_op == CSR_RC) && src_is_zero);
    assign read_only = csr_addr[11:10] == 2'b11
                    || (!HAS_MINSTRET && (csr_addr == CSR_MINSTRET || csr_addr == CSR_MINSTRETH));
    assign active = in_valid && csr_op != CSR_NONE;
    assign illegal = active && (!implemented || (read_only && write_attempt));
    assign we = active && !illegal && write_attempt && !trap_valid && !mret_valid;
    assign wdata = csr_op == CSR_RW ? csr_src : csr_op == CSR_RS ? old | csr_src : old & ~csr_src;
    assign csr_rdata = illegal ? '0 : old;
    assign redirect_pc = trap_valid ? {mtvec[XLEN-1:2], 2'b00} : mret_valid ? mepc : '0;
    assign mie_out = mie;

    always_ff @(posedge clock) begin
        if (reset) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mscratch <= '0;
        end else if (trap_valid) begin
            mepc   <= trap_pc & ~XLEN'(3);
            mcause <= trap_cause;
            mpie   <= mie;
            mie    <= 1'b0;
        end else if (mret_valid) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else if (we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie  <= wdata[MSTATUS_MIE];
                    mpie <= wdata[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec    <= wdata & ~XLEN'(3);
                CSR_MEPC:     mepc     <= wdata & ~XLEN'(3);
                CSR_MCAUSE:   mcause   <= wdata;
                CSR_MSCRATCH: mscratch <= wdata;
                default: ;
            endcase
        end
    end

    ysyx_25030093_csr_counter64 #(.W(XLEN)) u_mcycle (
        .clock(clock),
        .reset(reset),
        .inc(1'b1),
        .lo_we(we && csr_addr == CSR_MCYCLE),
        .hi_we(we && csr_addr == CSR_MCYCLEH),
        .wdata(wdata),
        .value(mcycle)
    );

    generate
        if (HAS_MINSTRET) begin : g_minstret
            ysyx_25030093_csr_counter64 #(.W(XLEN)) u_minstret (
                .clock(clock),
                .reset(reset),
                .inc(retire_valid),
                .lo_we(we && csr_addr == CSR_MINSTRET),
                .hi_we(we && csr_addr == CSR_MINSTRETH),
                .wdata(wdata),
                .value(minstret)
            );
        end else begin : g_no_minstret
            assign minstret = '0;
        end
    endgenerate
endmodule

// File: tb/tb_ysyx_25030093_csr_file.sv
// tb_ysyx_25030093_csr_file: directed scenarios plus randomized traffic against a reference model
module tb_ysyx_25030093_csr_file;
    logic clock = 1'b0, reset, in_valid, src_is_zero, trap_valid, mret_valid, retire_valid;
    logic [1:0] csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_src, trap_cause, trap_pc;
    logic [31:0] csr_rdata, redirect_pc;
    logic illegal, mie_out;
    int checks = 0, errors = 0;

    bit m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mscratch;
    logic [63:0] m_cycle, m_instret;

    ysyx_25030093_csr_file dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_src(csr_src), .src_is_zero(src_is_zero), .csr_rdata(csr_rdata), .illegal(illegal),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .mret_valid(mret_valid),
        .retire_valid(retire_valid), .redirect_pc(redirect_pc), .mie_out(mie_out)
    );

    always #5 clock = ~clock;

    function automatic bit m_impl(input logic [11:0] a);
        return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80,
                         12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hF11, 12'hF12};
    endfunction

    function automatic logic [31:0] m_val(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | {24'h0, m_mpie, 3'b000, m_mie, 3'b000};
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00, 12'hC00: return m_cycle[31:0];
            12'hB80, 12'hC80: return m_cycle[63:32];
            12'hB02: return m_instret[31:0];
            12'hB82: return m_instret[63:32];
            12'hF11: return 32'h79737978;
            12'hF12: return 32'd25030093;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_write_attempt();
        return !((csr_op == 2'b10 || csr_op == 2'b11) && src_is_zero);
    endfunction

    function automatic bit m_illegal();
        return in_valid && csr_op != 2'b00 && (!m_impl(csr_addr) || (csr_addr[11:10] == 2'b11 && m_write_attempt()));
    endfunction

    function automatic logic [31:0] m_rdata();
        return m_illegal() ? 32'h0 : m_val(csr_addr);
    endfunction

    function automatic logic [31:0] m_redirect();
        return trap_valid ? {m_mtvec[31:2], 2'b00} : mret_valid ? m_mepc : 32'h0;
    endfunction

    task automatic model_reset();
        m_mie = 0; m_mpie = 0;
        m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mscratch = 0;
        m_cycle = 0; m_instret = 0;
    endtask

    // advances one clock and applies the architectural effect of the current inputs to the model
    task automatic tick();
        bit we;
        logic [31:0] old, nv;
        old = m_val(csr_addr);
        nv = csr_op == 2'b01 ? csr_src : csr_op == 2'b10 ? (old | csr_src) : (old & ~csr_src);
        we = in_valid && csr_op != 2'b00 && !m_illegal() && m_write_attempt() && !trap_valid && !mret_valid;
        @(posedge clock);
        if (reset) model_reset();
        else begin
            if (we && csr_addr == 12'hB00) m_cycle = {m_cycle[63:32], nv};
            else if (we && csr_addr == 12'hB80) m_cycle = {nv, m_cycle[31:0] + 32'd1};
            else m_cycle = m_cycle + 64'd1;
            if (we && csr_addr == 12'hB02) m_instret = {m_instret[63:32], nv};
            else if (we && csr_addr == 12'hB82) m_instret = {nv, m_instret[31:0] + 32'(retire_valid)};
            else m_instret = m_instret + 64'(retire_valid);
            if (trap_valid) begin
                m_mepc = {trap_pc[31:2], 2'b00}; m_mcause = trap_cause; m_mpie = m_mie; m_mie = 0;
            end else if (mret_valid) begin
                m_mie = m_mpie; m_mpie = 1;
            end else if (we) begin
                case (csr_addr)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h305: m_mtvec = {nv[31:2], 2'b00};
                    12'h341: m_mepc = {nv[31:2], 2'b00};
                    12'h342: m_mcause = nv;
                    12'h340: m_mscratch = nv;
                    default: ;
                endcase
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] op, input logic [11:0] a, input logic [31:0] s, input bit z);
        in_valid = v; csr_op = op; csr_addr = a; csr_src = s; src_is_zero = z;
        trap_valid = 0; mret_valid = 0; retire_valid = 0; reset = 0;
        #1;
    endtask

    task automatic do_reset();
        drive(0, 2'b00, 12'h0, 0, 0);
        reset = 1; tick(); tick(); reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1, 2'b10, 12'h300, 0, 1);
        checks++; if (csr_rdata !== 32'h1800) begin errors++; $display("FAIL reset_mstatus got %h exp %h", csr_rdata, 32'h1800); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", illegal); end
        checks++; if (mie_out !== 1'b0) begin errors++; $display("FAIL reset_mie got %b exp 0", mie_out); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect got %h exp 0", redirect_pc); end
        tick(); drive(1, 2'b10, 12'hF11, 0, 1);
        checks++; if (csr_rdata !== 32'h79737978) begin errors++; $display("FAIL mvendorid got %h exp %h", csr_rdata, 32'h79737978); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL mvendorid_illegal got %b exp 0", illegal); end
        tick(); drive(1, 2'b11, 12'hF12, 0, 1);
        checks++; if (csr_rdata !== 32'd25030093) begin errors++; $display("FAIL marchid got %h exp %h", csr_rdata, 32'd25030093); end
        tick();
    endtask

    task automatic test_mtvec();
        drive(1, 2'b01, 12'h305, 32'h8000_0103, 0); tick();
        drive(1, 2'b11, 12'h305, 32'h100, 0);
        checks++; if (csr_rdata !== 32'h8000_0100) begin errors++; $display("FAIL mtvec_warl got %h exp %h", csr_rdata, 32'h8000_0100); end
        tick(); drive(1, 2'b10, 12'h305, 0, 1);
        checks++; if (csr_rdata !== 32'h8000_0000) begin errors++; $display("FAIL mtvec_rc got %h exp %h", csr_rdata, 32'h8000_0000); end
        tick();
    endtask

    task automatic test_illegal();
        drive(1, 2'b01, 12'hF11, 32'h5, 0);
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ro_write_illegal got %b exp 1", illegal); end
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL ro_write_rdata got %h exp 0", csr_rdata); end
        tick(); drive(1, 2'b10, 12'hF11, 0, 1);
        checks++; if (csr_rdata !== 32'h79737978) begin errors++; $display("FAIL ro_unchanged got %h exp %h", csr_rdata, 32'h79737978); end
        tick(); drive(1, 2'b10, 12'h7C0, 32'h1, 0);
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL unimpl_illegal got %b exp 1", illegal); end
        tick(); drive(1, 2'b10, 12'hC00, 32'h1, 0);
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL cycle_write_illegal got %b exp 1", illegal); end
        tick(); drive(0, 2'b01, 12'h7C0, 32'h1, 0);
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL invalid_not_illegal got %b exp 0", illegal); end
        tick();
    endtask

    task automatic test_trap_mret();
        drive(1, 2'b01, 12'h305, 32'h8000_0200, 0); tick();
        drive(1, 2'b10, 12'h300, 32'h8, 0); tick();
        drive(0, 2'b00, 12'h0, 0, 0);
        checks++; if (mie_out !== 1'b1) begin errors++; $display("FAIL mie_set got %b exp 1", mie_out); end
        trap_valid = 1; trap_cause = 32'd11; trap_pc = 32'h8000_0046; #1;
        checks++; if (redirect_pc !== 32'h8000_0200) begin errors++; $display("FAIL trap_redirect got %h exp %h", redirect_pc, 32'h8000_0200); end
        tick(); drive(1, 2'b10, 12'h341, 0, 1);
        checks++; if (csr_rdata !== 32'h8000_0044) begin errors++; $display("FAIL trap_mepc got %h exp %h", csr_rdata, 32'h8000_0044); end
        tick(); drive(1, 2'b10, 12'h342, 0, 1);
        checks++; if (csr_rdata !== 32'd11) begin errors++; $display("FAIL trap_mcause got %h exp %h", csr_rdata, 32'd11); end
        tick(); drive(1, 2'b10, 12'h300, 0, 1);
        checks++; if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL trap_mstatus got %h exp %h", csr_rdata, 32'h1880); end
        checks++; if (mie_out !== 1'b0) begin errors++; $display("FAIL trap_mie got %b exp 0", mie_out); end
        tick(); drive(0, 2'b00, 12'h0, 0, 0);
        mret_valid = 1; #1;
        checks++; if (redirect_pc !== 32'h8000_0044) begin errors++; $display("FAIL mret_redirect got %h exp %h", redirect_pc, 32'h8000_0044); end
        tick(); drive(1, 2'b10, 12'h300, 0, 1);
        checks++; if (csr_rdata !== 32'h1888) begin errors++; $display("FAIL mret_mstatus got %h exp %h", csr_rdata, 32'h1888); end
        tick();
    endtask

    task automatic test_counter();
        do_reset();
        drive(1, 2'b01, 12'hB00, 32'hFFFF_FFFE, 0); tick();
        drive(0, 2'b00, 12'h0, 0, 0); tick(); tick();
        drive(1, 2'b10, 12'hB00, 0, 1);
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mcycle_wrap got %h exp 0", csr_rdata); end
        tick(); drive(1, 2'b10, 12'hB80, 0, 1);
        checks++; if (csr_rdata !== 32'h1) begin errors++; $display("FAIL mcycleh_carry got %h exp 1", csr_rdata); end
        tick(); drive(1, 2'b10, 12'hC80, 0, 1);
        checks++; if (csr_rdata !== 32'h1) begin errors++; $display("FAIL cycleh_alias got %h exp 1", csr_rdata); end
        tick(); drive(1, 2'b01, 12'hB00, 32'hFFFF_FFFE, 0); tick();
        drive(0, 2'b00, 12'h0, 0, 0); tick();
        drive(1, 2'b01, 12'hB80, 32'h7, 0); tick();
        drive(1, 2'b10, 12'hB80, 0, 1);
        checks++; if (csr_rdata !== 32'h7) begin errors++; $display("FAIL mcycleh_write got %h exp 7", csr_rdata); end
        tick(); drive(1, 2'b10, 12'hB00, 0, 1);
        checks++; if (csr_rdata !== 32'h1) begin errors++; $display("FAIL mcycle_after_hi_write got %h exp 1", csr_rdata); end
        tick();
    endtask

    task automatic test_trap_priority();
        do_reset();
        drive(1, 2'b01, 12'h340, 32'hDEAD, 0);
        trap_valid = 1; trap_cause = 32'd2; trap_pc = 32'h8000_1003; #1;
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL prio_illegal got %b exp 0", illegal); end
        tick(); drive(1, 2'b10, 12'h340, 0, 1);
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL prio_mscratch got %h exp 0", csr_rdata); end
        tick(); drive(1, 2'b10, 12'h341, 0, 1);
        checks++; if (csr_rdata !== 32'h8000_1000) begin errors++; $display("FAIL prio_mepc got %h exp %h", csr_rdata, 32'h8000_1000); end
        tick(); drive(0, 2'b00, 12'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin retire_valid = 1; tick(); end
        drive(1, 2'b10, 12'hB02, 0, 1);
        checks++; if (csr_rdata !== 32'd3) begin errors++; $display("FAIL minstret got %h exp 3", csr_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1, 2'b01, 12'h340, 32'h1234, 0); tick();
        drive(1, 2'b10, 12'h300, 32'h88, 0);
        reset = 1; trap_valid = 1; retire_valid = 1; #1; tick();
        drive(1, 2'b10, 12'h300, 0, 1);
        checks++; if (csr_rdata !== 32'h1800) begin errors++; $display("FAIL mid_reset_mstatus got %h exp %h", csr_rdata, 32'h1800); end
        tick(); drive(1, 2'b10, 12'h340, 0, 1);
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mid_reset_mscratch got %h exp 0", csr_rdata); end
        tick(); drive(1, 2'b10, 12'hB02, 0, 1);
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mid_reset_minstret got %h exp 0", csr_rdata); end
        tick();
    endtask

    task automatic test_random();
        logic [11:0] addrs [16] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'hB02,
                                    12'hB82, 12'hC00, 12'hC80, 12'hF11, 12'hF12, 12'h7C0, 12'h301, 12'hF13};
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom), addrs[$urandom_range(0, 15)],
                  $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom,
                  $urandom_range(0, 3) == 0);
            trap_valid = $urandom_range(0, 9) == 0;
            mret_valid = $urandom_range(0, 9) == 0;
            retire_valid = 1'($urandom);
            trap_cause = $urandom; trap_pc = $urandom;
            reset = $urandom_range(0, 60) == 0;
            #1;
            checks++; if (csr_rdata !== m_rdata()) begin errors++; $display("FAIL rnd_rdata addr %h got %h exp %h", csr_addr, csr_rdata, m_rdata()); end
            checks++; if (illegal !== m_illegal()) begin errors++; $display("FAIL rnd_illegal addr %h got %b exp %b", csr_addr, illegal, m_illegal()); end
            checks++; if (redirect_pc !== m_redirect()) begin errors++; $display("FAIL rnd_redirect got %h exp %h", redirect_pc, m_redirect()); end
            checks++; if (mie_out !== m_mie) begin errors++; $display("FAIL rnd_mie got %b exp %b", mie_out, m_mie); end
            tick();
        end
    endtask

    initial begin
        trap_cause = 0; trap_pc = 0;
        model_reset();
        test_reset();
        test_mtvec();
        test_illegal();
        test_trap_mret();
        test_counter();
        test_trap_priority();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_25030093_csr_file.md
Name: ysyx_25030093_csr_file

Overview:
Parametrised machine-mode CSR unit that supersedes the fixed 8-entry CSR array.
- Executes CSRRW/CSRRS/CSRRC read-modify-write internally.
- Flags illegal accesses.
- Handles trap entry and mret with mstatus MIE/MPIE stacking and produces the redirect PC.
- Maintains 64-bit mcycle/minstret counters with split-half writes.
- Sits beside the GPR file in the EXU/WBU stage; redirect_pc feeds the IFU.

Parameters:
XLEN, 32, data width of every CSR port
VENDOR_ID, 32'h79737978, mvendorid read value
ARCH_ID, 32'd25030093, marchid read value
HAS_MINSTRET, 1, 1 implements minstret/minstreth; 0 makes them read-zero and illegal to write

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
in_valid  in  1  instruction in this stage is valid
csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC
csr_addr  in  12  CSR address
csr_src  in  XLEN  rs1 value or zimm
src_is_zero  in  1  rs1 index or zimm is 0
csr_rdata  out  XLEN  old CSR value (combinational)
illegal  out  1  access is illegal (combinational)
trap_valid  in  1  take synchronous exception this cycle
trap_cause  in  XLEN  mcause value to record
trap_pc  in  XLEN  faulting PC
mret_valid  in  1  execute mret
retire_valid  in  1  one instruction retired
redirect_pc  out  XLEN  trap target or mret target (combinational)
mie_out  out  1  mstatus.MIE

Behaviour:
- Implemented CSRs:
  - mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mscratch 0x340.
  - mcycle 0xB00 / mcycleh 0xB80, minstret 0xB02 / minstreth 0xB82.
  - Read-only: mvendorid 0xF11, marchid 0xF12, cycle 0xC00, cycleh 0xC80.
- Reset values:
  - mstatus = 32'h1800 (MPP=11, MIE=0, MPIE=0).
  - mtvec, mepc, mcause, mscratch = 0; all counters = 0.
  - Outputs follow from these values: mie_out = 0, csr_rdata per address.
- Write enable we = in_valid & csr_op != 0 & !illegal & !(csr_op in {RS,RC} & src_is_zero).
- New value:
  - RW → csr_src.
  - RS → old | csr_src.
  - RC → old & ~csr_src.
  - Committed at the next posedge (1-cycle latency); csr_rdata always shows the pre-write value.
- illegal = in_valid & csr_op != 0 & (address unimplemented, OR (addr[11:10]==2'b11 & write attempted)).
  - A write is attempted unless the op is RS/RC with src_is_zero.
  - CSRRS x0 to mvendorid is legal.
  - When illegal, csr_rdata = 0 and no state changes.
- WARL rules:
  - mtvec[1:0] and mepc[1:0] always read 0 (direct mode only).
  - mstatus writable bits are MIE[3] and MPIE[7] only; MPP reads 2'b11 always; other bits read 0.
- Trap (trap_valid):
  - mepc ← trap_pc & ~3; mcause ← trap_cause.
  - mstatus.MPIE ← MIE; MIE ← 0.
  - redirect_pc = {mtvec[XLEN-1:2],2'b00}.
- mret (mret_valid):
  - MIE ← MPIE; MPIE ← 1.
  - redirect_pc = mepc.
- redirect_pc = 0 when neither trap_valid nor mret_valid.
- Priority (same cycle): reset > trap > mret > CSR write.
  - A suppressed CSR write is dropped, not deferred.
  - trap & mret together: trap wins.
- Counters:
  - mcycle increments every non-reset cycle.
  - minstret increments when retire_valid.
  - Low-half overflow 0xFFFFFFFF carries into the high half in the same edge.
- Counter write:
  - Writing the low half loads wdata; the high half holds (no carry that edge).
  - Writing the high half loads wdata; the low half still increments, and its carry is discarded.
  - Written value is visible the next cycle with no increment applied.
- Reset mid-operation: all state returns to reset values on the reset edge, regardless of other inputs.

Decomposition:
- Package ysyx_25030093_csr_pkg holds:
  - CSR address localparams.
  - csr_op encodings (CSR_NONE/RW/RS/RC).
  - mstatus bit indices (MIE=3, MPIE=7, MPP=12:11).
  - The mstatus reset constant.
- Sub-module ysyx_25030093_csr_counter64:
  - 64-bit counter with inc enable, lo_we/hi_we, wdata.
  - Instantiated twice (mcycle, minstret), the latter under HAS_MINSTRET generate.

Test Plan:
- Reset, then read 0x300/0xF11/0xF12 via RS with src_is_zero → 32'h1800, 32'h79737978, 32'd25030093, illegal=0.
- RW 0x305 with 32'h8000_0103, then read → 32'h8000_0100; RC 0x305 with 32'h100 → old value returned, next read 32'h8000_0000.
- RW 0xF11 with 5 → illegal=1, csr_rdata=0, mvendorid unchanged; RS to 0x7C0 (unimplemented) → illegal=1.
- Set MIE=1 via RS 0x300 with 8, then trap_valid with cause 11, pc 32'h8000_0046 → redirect_pc = mtvec; next mepc=32'h8000_0044, mcause=11, mstatus=32'h1880. Then mret → redirect_pc=32'h8000_0044; next mstatus=32'h1888.
- RW 0xB00 with 32'hFFFF_FFFE → after 2 cycles mcycle=0, mcycleh=1. Also RW 0xB80 with 7 in the same cycle a low overflow occurs → mcycleh=7.
- trap_valid concurrent with RW 0x340 with 32'hDEAD → mscratch stays 0, trap state updated; retire_valid held 3 cycles → minstret=3.
